// File: rtl/fma_pkg.sv
// Shared definitions for the FMA add-stage pipeline controller:
// operation encodings, default widths/thresholds and stage payload types.
package fma_pkg;

    localparam logic [1:0] FMADD  = 2'b00;
    localparam logic [1:0] FMSUB  = 2'b01;
    localparam logic [1:0] FNMSUB = 2'b10;
    localparam logic [1:0] FNMADD = 2'b11;

    localparam int TAGW_DEF   = 4;
    localparam int EXPW_DEF   = 11;
    localparam int BIAS_DEF   = 1023;
    localparam int KILLTH_DEF = 55;

    // Operation state carried from M into A.
    typedef struct packed {
        logic [TAGW_DEF-1:0]        tag;
        logic                       ps;
        logic                       zs;
        logic signed [EXPW_DEF+1:0] d;
        logic                       pd;
    } payload_t;

    // Operation state carried from A into N.
    typedef struct packed {
        logic [TAGW_DEF-1:0] tag;
        logic                rs;
    } result_t;

    // The product sign flips for the negated forms.
    function automatic logic prod_neg(logic [1:0] op);
        return !((op == FMADD) || (op == FMSUB));
    endfunction

    // The addend sign flips for the subtracting forms.
    function automatic logic add_neg(logic [1:0] op);
        return !((op == FMADD) || (op == FNMADD));
    endfunction

endpackage

// File: rtl/fma_add_ctrl_if.sv
// Request/result handshake bundle between an issuer and the FMA controller.
interface fma_add_ctrl_if #(
    parameter int TAGW = 4,
    parameter int EXPW = 11
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [TAGW-1:0] req_tag;
    logic            xsign, ysign, zsign;
    logic [EXPW-1:0] xexp, yexp, zexp;
    logic            xdenorm, ydenorm;
    logic            res_valid;
    logic            res_ready;
    logic [TAGW-1:0] res_tag;
    logic            res_sign;

    modport master (
        output req_valid, req_op, req_tag, xsign, ysign, zsign,
               xexp, yexp, zexp, xdenorm, ydenorm, res_ready,
        input  req_ready, res_valid, res_tag, res_sign
    );

    modport slave (
        input  req_valid, req_op, req_tag, xsign, ysign, zsign,
               xexp, yexp, zexp, xdenorm, ydenorm, res_ready,
        output req_ready, res_valid, res_tag, res_sign
    );
endinterface

// File: rtl/fma_stage_reg.sv
// One pipeline stage: valid bit plus payload, loaded on enable,
// emptied by a synchronous clear (flush) or reset.
module fma_stage_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic vld_in,
    input  T     data_in,
    output logic vld_out,
    output T     data_out
);
    logic vld_d, vld_q;
    T     data_d, data_q;

    // Clear wins over load; a disabled stage holds.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr) begin
            vld_d  = 1'b0;
            data_d = '0;
        end else if (en) begin
            vld_d  = vld_in;
            data_d = data_in;
        end
    end

    // Stage state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_out  = vld_q;
    assign data_out = data_q;
endmodule

// File: rtl/fma_add_ctrl.sv
// Three-stage (M/A/N) FMA pipeline controller: elastic valid tracking with
// bubble collapse, add-stage control generation and tagged result delivery.
module fma_add_ctrl
    import fma_pkg::*;
#(
    parameter int TAGW   = TAGW_DEF,
    parameter int EXPW   = EXPW_DEF,
    parameter int BIAS   = BIAS_DEF,
    parameter int KILLTH = KILLTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    fma_add_ctrl_if.slave       bus,
    output logic                en_m,
    output logic                en_a,
    output logic                en_n,
    output logic                invz,
    output logic                killprod,
    output logic                proddenorm,
    input  logic                negsum0,
    input  logic                negsum1,
    output logic                selsum1,
    output logic                negsum,
    output logic [1:0]          inflight
);
    localparam int DW = EXPW + 2;
    localparam logic signed [DW-1:0] BIAS_W = DW'(BIAS);
    localparam logic signed [DW-1:0] KILL_W = DW'(KILLTH);

    logic v_m, v_a, v_n;
    logic vm_e, va_e, vn_e;
    logic accept;
    logic clr;
    payload_t m_d, m_q, a_q;
    result_t  n_d, n_q;
    logic a_invz, a_kill, a_negsum, a_selsum1;
    logic [TAGW-1:0] tag_in;
    logic signed [DW-1:0] xe, ye, ze;
    logic unused_negsum1;

    // The +1-mode sign is not needed to pick between the two adder results.
    assign unused_negsum1 = negsum1;

    assign clr = flush;

    // Stage enables and handshake; reset makes the pipe look empty at once.
    always_comb begin
        vm_e          = v_m & ~reset;
        va_e          = v_a & ~reset;
        vn_e          = v_n & ~reset;
        en_n          = ~vn_e | bus.res_ready;
        en_a          = ~va_e | en_n;
        en_m          = ~vm_e | en_a;
        bus.req_ready = en_m & ~reset & ~flush;
        accept        = bus.req_valid & bus.req_ready;
        inflight      = {1'b0, vm_e} + {1'b0, va_e} + {1'b0, vn_e};
    end

    // M-stage capture: effective signs and the addend-vs-product exponent gap.
    always_comb begin
        tag_in  = bus.req_tag;
        xe      = {2'b00, bus.xexp};
        ye      = {2'b00, bus.yexp};
        ze      = {2'b00, bus.zexp};
        m_d.tag = tag_in;
        m_d.ps  = bus.xsign ^ bus.ysign ^ prod_neg(bus.req_op);
        m_d.zs  = bus.zsign ^ add_neg(bus.req_op);
        m_d.d   = ze - (xe + ye - BIAS_W);
        m_d.pd  = bus.xdenorm | bus.ydenorm;
    end

    // A-stage controls and the sign handed to N.
    always_comb begin
        a_invz     = a_q.ps ^ a_q.zs;
        a_kill     = $signed(a_q.d) > $signed(KILL_W);
        a_negsum   = a_invz & negsum0;
        a_selsum1  = a_invz & ~negsum0;
        n_d.tag    = a_q.tag;
        n_d.rs     = (a_kill & ~a_q.pd) ? a_q.zs : (a_q.ps ^ a_negsum);
        invz       = va_e & a_invz;
        killprod   = va_e & a_kill;
        proddenorm = va_e & a_q.pd;
        negsum     = va_e & a_negsum;
        selsum1    = va_e & a_selsum1;
    end

    // N-stage result presentation.
    always_comb begin
        bus.res_valid = vn_e;
        bus.res_tag   = reset ? '0 : n_q.tag;
        bus.res_sign  = reset ? 1'b0 : n_q.rs;
    end

    fma_stage_reg #(.T(payload_t)) u_stage_m (
        .clk(clk), .reset(reset), .clr(clr), .en(en_m),
        .vld_in(accept), .data_in(m_d), .vld_out(v_m), .data_out(m_q)
    );

    fma_stage_reg #(.T(payload_t)) u_stage_a (
        .clk(clk), .reset(reset), .clr(clr), .en(en_a),
        .vld_in(v_m), .data_in(m_q), .vld_out(v_a), .data_out(a_q)
    );

    fma_stage_reg #(.T(result_t)) u_stage_n (
        .clk(clk), .reset(reset), .clr(clr), .en(en_n),
        .vld_in(v_a), .data_in(n_d), .vld_out(v_n), .data_out(n_q)
    );
endmodule

// File: tb/tb_fma_add_ctrl.sv
// Bench for fma_add_ctrl: directed scenarios plus randomized traffic, all
// checked against a slot-compaction reference of the three-deep pipe.
module tb_fma_add_ctrl;
    logic       clk = 1'b0;
    logic       reset, flush;
    logic       en_m, en_a, en_n, invz, killprod, proddenorm;
    logic       negsum0, negsum1, selsum1, negsum;
    logic [1:0] inflight;

    fma_add_ctrl_if #(.TAGW(4), .EXPW(11)) bus ();

    fma_add_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus),
        .en_m(en_m), .en_a(en_a), .en_n(en_n),
        .invz(invz), .killprod(killprod), .proddenorm(proddenorm),
        .negsum0(negsum0), .negsum1(negsum1),
        .selsum1(selsum1), .negsum(negsum), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit ps;
        bit zs;
        bit pd;
        int d;
        bit rs;
    } op_t;

    op_t slot[3];
    bit  full[3];
    int  exp_q[$];
    int  got_tags[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    int s_res_valid, s_res_tag, s_res_sign, s_req_ready, s_inflight, s_ens;
    int s_invz, s_kill, s_pd, s_negsum, s_selsum1;

    int o_rv1, o_rv2, o_rv3, o_invz, o_kill, o_pd, o_neg, o_sel, o_sign, o_tag;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Expected operation record straight from the operand rules.
    function automatic op_t mk_op();
        op_t o;
        o.tag = int'(bus.req_tag);
        o.ps  = bus.xsign ^ bus.ysign ^ (bus.req_op inside {2'b10, 2'b11});
        o.zs  = bus.zsign ^ (bus.req_op inside {2'b01, 2'b10});
        o.d   = int'(bus.zexp) - (int'(bus.xexp) + int'(bus.yexp) - 1023);
        o.pd  = bus.xdenorm | bus.ydenorm;
        o.rs  = 1'b0;
        return o;
    endfunction

    // Observe one cycle against the reference, then advance it by one clock.
    task automatic tick();
        bit f0, f1, f2;
        bit e_en_n, e_en_a, e_en_m, e_ready;
        bit a_invz, a_kill, a_neg, a_sel, a_rs;
        op_t a;
        #1;
        f0 = full[0] && !reset;
        f1 = full[1] && !reset;
        f2 = full[2] && !reset;
        e_en_n  = !f2 || bus.res_ready;
        e_en_a  = !f1 || !f2 || bus.res_ready;
        e_en_m  = !f0 || !f1 || !f2 || bus.res_ready;
        e_ready = e_en_m && !reset && !flush;
        a       = slot[1];
        a_invz  = a.ps ^ a.zs;
        a_kill  = a.d > 55;
        a_neg   = a_invz & negsum0;
        a_sel   = a_invz & !negsum0;
        a_rs    = (a_kill && !a.pd) ? a.zs : (a.ps ^ a_neg);

        chk("en_n", en_n, e_en_n);
        chk("en_a", en_a, e_en_a);
        chk("en_m", en_m, e_en_m);
        chk("req_ready", bus.req_ready, e_ready);
        chk("inflight", inflight, int'(f0) + int'(f1) + int'(f2));
        chk("res_valid", bus.res_valid, f2);
        chk("invz", invz, f1 & a_invz);
        chk("killprod", killprod, f1 & a_kill);
        chk("proddenorm", proddenorm, f1 & a.pd);
        chk("negsum", negsum, f1 & a_neg);
        chk("selsum1", selsum1, f1 & a_sel);
        if (f2) begin
            chk("res_tag", bus.res_tag, slot[2].tag);
            chk("res_sign", bus.res_sign, slot[2].rs);
        end
        if (reset) begin
            chk("rst_res_tag", bus.res_tag, 0);
            chk("rst_res_sign", bus.res_sign, 0);
        end

        s_res_valid = bus.res_valid;
        s_res_tag   = bus.res_tag;
        s_res_sign  = bus.res_sign;
        s_req_ready = bus.req_ready;
        s_inflight  = inflight;
        s_ens       = {en_m, en_a, en_n};
        s_invz      = invz;
        s_kill      = killprod;
        s_pd        = proddenorm;
        s_negsum    = negsum;
        s_selsum1   = selsum1;

        if (f2 && bus.res_ready) begin
            got_tags.push_back(int'(bus.res_tag));
            chk("retire_known", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("retire_order", bus.res_tag, exp_q.pop_front());
        end

        if (reset || flush) begin
            full = '{0, 0, 0};
            exp_q.delete();
        end else begin
            if (f2 && bus.res_ready) full[2] = 0;
            if (!full[2] && full[1]) begin
                slot[2]    = slot[1];
                slot[2].rs = a_rs;
                full[2]    = 1;
                full[1]    = 0;
            end
            if (!full[1] && full[0]) begin
                slot[1] = slot[0];
                full[1] = 1;
                full[0] = 0;
            end
            if (!full[0] && bus.req_valid) begin
                slot[0] = mk_op();
                full[0] = 1;
                exp_q.push_back(int'(bus.req_tag));
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input int tag, input bit xs, input bit ys,
                         input bit zs, input int xe, input int ye, input int ze,
                         input bit xd, input bit yd);
        bus.req_op  = op;
        bus.req_tag = tag[3:0];
        bus.xsign   = xs;
        bus.ysign   = ys;
        bus.zsign   = zs;
        bus.xexp    = xe[10:0];
        bus.yexp    = ye[10:0];
        bus.zexp    = ze[10:0];
        bus.xdenorm = xd;
        bus.ydenorm = yd;
    endtask

    // Issue the currently driven operation into an idle pipe and follow it out.
    task automatic run_one();
        bus.res_ready = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        chk("one_accept", s_req_ready, 1);
        bus.req_valid = 1'b0;
        tick();
        o_rv1 = s_res_valid;
        tick();
        o_rv2  = s_res_valid;
        o_invz = s_invz;
        o_kill = s_kill;
        o_pd   = s_pd;
        o_neg  = s_negsum;
        o_sel  = s_selsum1;
        tick();
        o_rv3  = s_res_valid;
        o_sign = s_res_sign;
        o_tag  = s_res_tag;
        tick();
    endtask

    initial begin
        int cur;
        int tag_ctr;
        reset = 1'b1;
        flush = 1'b0;
        negsum0 = 1'b0;
        negsum1 = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        full = '{0, 0, 0};
        @(negedge clk);

        tick();
        chk("rst_req_ready", s_req_ready, 0);
        chk("rst_res_valid", s_res_valid, 0);
        chk("rst_ens", s_ens, 7);
        chk("rst_inflight", s_inflight, 0);
        tick();
        reset = 1'b0;
        tick();

        // plain fmadd
        drive(2'b00, 3, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        run_one();
        chk("t1_rv_c1", o_rv1, 0);
        chk("t1_rv_c2", o_rv2, 0);
        chk("t1_rv_c3", o_rv3, 1);
        chk("t1_invz", o_invz, 0);
        chk("t1_kill", o_kill, 0);
        chk("t1_tag", o_tag, 3);

        // effective subtract, adder says negative
        negsum0 = 1'b1;
        drive(2'b01, 4, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        run_one();
        chk("t2a_invz", o_invz, 1);
        chk("t2a_negsum", o_neg, 1);
        chk("t2a_selsum1", o_sel, 0);
        chk("t2a_sign", o_sign, 1);

        // effective subtract, adder says positive
        negsum0 = 1'b0;
        drive(2'b01, 5, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        run_one();
        chk("t2b_selsum1", o_sel, 1);
        chk("t2b_negsum", o_neg, 0);
        chk("t2b_sign", o_sign, 0);

        // addend dominates: sign comes from z
        drive(2'b00, 6, 0, 0, 1, 1023, 1023, 1083, 0, 0);
        run_one();
        chk("t3_kill", o_kill, 1);
        chk("t3_pd", o_pd, 0);
        chk("t3_sign", o_sign, 1);

        // denormal product overrides the kill sign choice
        drive(2'b00, 7, 0, 0, 1, 1023, 1023, 1083, 1, 0);
        run_one();
        chk("t3d_pd", o_pd, 1);
        chk("t3d_sign", o_sign, 0);

        // gap exactly at and just over the threshold
        drive(2'b00, 8, 0, 0, 0, 1023, 1023, 1078, 0, 0);
        run_one();
        chk("gap55_kill", o_kill, 0);
        drive(2'b00, 9, 0, 0, 0, 1023, 1023, 1079, 0, 0);
        run_one();
        chk("gap56_kill", o_kill, 1);

        // backpressure with five back-to-back requests
        bus.res_ready = 1'b0;
        cur = 1;
        got_tags.delete();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = (cur <= 5);
            drive(2'b00, cur, 0, 1, 0, 1000, 1040, 1023, 0, 0);
            tick();
            if (bus.req_valid && s_req_ready != 0) cur++;
            if (i >= 3) begin
                chk("bp_inflight", s_inflight, 3);
                chk("bp_req_ready", s_req_ready, 0);
                chk("bp_ens", s_ens, 0);
                chk("bp_tag_hold", s_res_tag, 1);
            end
        end
        bus.res_ready = 1'b1;
        for (int i = 0; i < 20 && got_tags.size() < 5; i++) begin
            bus.req_valid = (cur <= 5);
            drive(2'b00, cur, 0, 1, 0, 1000, 1040, 1023, 0, 0);
            tick();
            if (bus.req_valid && s_req_ready != 0) cur++;
        end
        bus.req_valid = 1'b0;
        chk("bp_count", got_tags.size(), 5);
        for (int i = 0; i < 5 && i < got_tags.size(); i++) chk("bp_seq", got_tags[i], i + 1);

        // flush a full pipe while a request is offered
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 10 + i, 1, 0, 1, 1023, 1023, 1023, 0, 0);
            tick();
        end
        flush = 1'b1;
        drive(2'b00, 13, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        tick();
        chk("fl_req_ready", s_req_ready, 0);
        chk("fl_inflight_before", s_inflight, 3);
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        got_tags.delete();
        tick();
        chk("fl_inflight_after", s_inflight, 0);
        repeat (4) tick();
        chk("fl_nothing_out", got_tags.size(), 0);

        // reset mid-stream
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        drive(2'b11, 14, 1, 1, 0, 1023, 1023, 1023, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_res_valid", s_res_valid, 0);
        chk("mrst_req_ready", s_req_ready, 0);
        chk("mrst_inflight", s_inflight, 0);
        chk("mrst_ens", s_ens, 7);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        chk("mrst_after_inflight", s_inflight, 0);
        drive(2'b00, 15, 0, 0, 0, 1023, 1023, 1023, 0, 0);
        run_one();
        chk("mrst_rv_c2", o_rv2, 0);
        chk("mrst_rv_c3", o_rv3, 1);
        chk("mrst_tag", o_tag, 15);

        // randomized traffic
        tag_ctr = 0;
        for (int i = 0; i < 3000; i++) begin
            int xe, ye, ze;
            if ($urandom_range(0, 3) == 0) begin
                xe = $urandom_range(0, 2047);
                ye = $urandom_range(0, 2047);
                ze = $urandom_range(0, 2047);
            end else begin
                xe = 1000 + $urandom_range(0, 46);
                ye = 1000 + $urandom_range(0, 46);
                ze = 1000 + $urandom_range(0, 130);
            end
            drive(2'($urandom_range(0, 3)), tag_ctr, 1'($urandom), 1'($urandom), 1'($urandom),
                  xe, ye, ze, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            tag_ctr       = (tag_ctr + 1) % 16;
            bus.req_valid = $urandom_range(0, 9) < 7;
            bus.res_ready = $urandom_range(0, 9) < 6;
            flush         = $urandom_range(0, 99) < 3;
            reset         = $urandom_range(0, 199) == 0;
            negsum0       = 1'($urandom);
            negsum1       = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fma_add_ctrl.md
Name: fma_add_ctrl

Overview:
- Pipeline controller for the three-stage FMA unit: M (multiply, partial products), A (compound add), N (normalize/round).
- Accepts operations through a valid/ready handshake and tracks per-stage valid bits with bubble-collapsing stalls.
- Computes the add-stage controls (invz, killprod, proddenorm, selsum1, negsum) from operand signs and exponents, and from adder sign feedback.
- Delivers a tagged result handshake at N.

Parameters:
- TAGW, 4, width of the operation tag carried through the pipeline
- EXPW, 11, operand exponent width
- BIAS, 1023, exponent bias
- KILLTH, 55, exponent gap above which the addend dominates the product

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all in-flight operations
- req_valid  in  1  operation offered
- req_ready  out  1  operation accepted when req_valid & req_ready
- req_op  in  2  00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd
- req_tag  in  TAGW  destination tag
- xsign, ysign, zsign  in  1 each  operand signs
- xexp, yexp, zexp  in  EXPW each  biased exponents
- xdenorm, ydenorm  in  1 each  multiplicand is denormal
- en_m, en_a, en_n  out  1 each  datapath stage register enables
- invz  out  1  A-stage addend invert
- killprod  out  1  A-stage product kill
- proddenorm  out  1  A-stage product-denormal override
- negsum0, negsum1  in  1 each  adder sign feedback in +0 / +1 modes
- selsum1  out  1  select +1 adder result
- negsum  out  1  negate adder result
- res_valid  out  1  result valid at N
- res_ready  in  1  consumer accepts result
- res_tag  out  TAGW  tag of N-stage operation
- res_sign  out  1  final sign of N-stage result
- inflight  out  2  number of valid stages, 0..3

Behaviour:
- Valid bits and stage enables
  - Valid bits v_m, v_a, v_n.
  - en_n = ~v_n | res_ready; en_a = ~v_a | en_n; en_m = ~v_m | en_a.
  - req_ready = en_m & ~reset & ~flush.
  - Accept: v_m <= req_valid & req_ready when en_m.
  - Advance: v_a <= v_m when en_a; v_n <= v_a when en_n; when en_n and not en_a... not applicable. A stage that drains downstream without a refill from upstream clears its valid bit.
- Latency: 3 cycles accept-to-res_valid with no stall; throughput 1 op/cycle.
- res_valid = v_n.
- M stage registers, on accept:
  - ps = xsign ^ ysign ^ op[1]
  - zs = zsign ^ op[0] ^ op[1]
  - tag
  - d = zexp - (xexp + yexp - BIAS), computed (EXPW+2)-bit signed, no saturation
  - pd = xdenorm | ydenorm
- A-stage outputs, combinational from A registers (all 0 when ~v_a):
  - invz = ps ^ zs
  - killprod = (d > KILLTH)
  - proddenorm = pd
  - negsum = invz & negsum0
  - selsum1 = invz & ~negsum0
  - A stage captures rsign = (killprod & ~proddenorm) ? zs : (ps ^ negsum) into its N register.
- N stage: res_sign, res_tag driven from N registers; both hold stable while res_valid & ~res_ready.
- flush: clears v_m, v_a, v_n next cycle and blocks acceptance that cycle; overrides a simultaneous accept. res_valid in the flush cycle still reflects current v_n; a handshake completing in that cycle counts.
- inflight = v_m + v_a + v_n.
- Reset: all valid bits 0; res_valid 0, req_ready 0 while reset asserted; all A-stage controls 0, res_tag 0, res_sign 0, inflight 0, en_* 1. Reset mid-operation discards everything, identically to flush.
- Boundaries
  - Full (inflight=3, res_ready=0): req_ready=0, all enables 0, registers hold.
  - res_ready rising with a full pipe: all three stages advance and req_ready=1 in the same cycle.
  - Bubbles collapse: v_m=1, v_a=0, v_n=1 stalled gives en_a=1, en_m=1.

Decomposition:
- Shared package fma_pkg:
  - op encoding constants FMADD/FMSUB/FNMSUB/FNMADD
  - BIAS, KILLTH defaults
  - stage-payload typedef {tag, ps, zs, d, pd}
- One sub-module fma_stage_reg: a payload register with enable and synchronous clear, instantiated for M, A, N.

Test Plan:
- Single fmadd: x,y,z signs 0, exps 1023/1023/1023, res_ready=1 -> res_valid exactly 3 cycles after accept, invz=0, killprod=0, res_tag echoes.
- Effective subtract: fmsub, all signs 0, negsum0=1 in A cycle -> invz=1, negsum=1, selsum1=0, res_sign=1. Same with negsum0=0 -> selsum1=1, res_sign=0.
- Kill: zexp=1023+60, xexp=yexp=1023, zsign=1 -> killprod=1, res_sign=1. With xdenorm=1 -> proddenorm=1 and sign taken from the sum path.
- Backpressure: 5 back-to-back requests, res_ready=0 for 4 cycles -> inflight reaches 3, req_ready=0, res_tag stable. Release -> tags emerge in order, no loss or duplication.
- Flush with 3 in flight and req_valid=1 -> next cycle inflight=0, no accept that cycle, nothing emerges afterward.
- Reset asserted mid-stream for 1 cycle -> all outputs at reset values; a new request after reset completes normally in 3 cycles.
